// File: rtl/uart_bram_loopback.sv
// UART 8N1 receiver, DEPTH-byte block-RAM buffer and 8N1 transmitter loopback.
// Once the buffer holds DEPTH bytes they are sent back on Tx in arrival order.
//
// Ports:
//   Clk        : system clock, rising edge
//   Rst_n      : asynchronous active-low reset
//   En         : 0 holds the RX/TX engines idle (sequencer and pointers held)
//   Rx         : serial in, idle high, asynchronous to Clk
//   Tx         : serial out, idle high
//   TxDone     : one-cycle pulse when a transmitted stop bit completes
//   LEDOut     : last received byte
//   SSD_Out    : seven-segment cathodes, active-low, {dp, g..a}
//   SSD_Select : digit anodes, active-low
//
// Optional macro UART_BRAM_LOOPBACK_SSD_EN adds the multiplexed seven-segment
// driver; without it the display is blank and REFRESH_BITS does not exist.
module uart_bram_loopback #(
    parameter int CLKS_PER_BIT = 10417,
    parameter int DEPTH        = 8
`ifdef UART_BRAM_LOOPBACK_SSD_EN
    ,
    parameter int REFRESH_BITS = 18
`endif
) (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic       En,
    input  logic       Rx,
    output logic       Tx,
    output logic       TxDone,
    output logic [7:0] LEDOut,
    output logic [7:0] SSD_Out,
    output logic [3:0] SSD_Select
);

    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam int AW = $clog2(DEPTH);
    localparam int NW = AW + 1;
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    // Rx synchronizer, reset to the idle (high) level
    logic rx_s1, rx_s2;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
        end else begin
            rx_s1 <= Rx;
            rx_s2 <= rx_s1;
        end
    end

    // ---------------- RX FSM ----------------
    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_CLEAN
    } rx_st_t;

    rx_st_t          rx_st, rx_nx;
    logic [CW-1:0]   rx_cnt;
    logic [2:0]      rx_bit;
    logic [7:0]      rx_byte;
    logic            rx_tick, rx_half, rx_wr;

    assign rx_tick = (rx_cnt == BIT_LAST);
    assign rx_half = (rx_cnt == HALF_LAST);

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            rx_st   <= RX_IDLE;
            rx_cnt  <= '0;
            rx_bit  <= '0;
            rx_byte <= '0;
        end else begin
            rx_st <= rx_nx;
            if (rx_st == RX_IDLE || rx_nx != rx_st || rx_tick)
                rx_cnt <= '0;
            else
                rx_cnt <= rx_cnt + 1'b1;
            if (rx_st != RX_DATA)
                rx_bit <= '0;
            else if (rx_tick)
                rx_bit <= rx_bit + 1'b1;
            if (rx_st == RX_DATA && rx_tick)
                rx_byte[rx_bit] <= rx_s2;
        end
    end

    always_comb begin
        rx_nx = rx_st;
        if (!En) begin
            rx_nx = RX_IDLE;
        end else begin
            unique case (rx_st)
                RX_IDLE:  if (!rx_s2) rx_nx = RX_START;
                // mid-start sample: a high level here was only a glitch
                RX_START: if (rx_half) rx_nx = rx_s2 ? RX_IDLE : RX_DATA;
                RX_DATA:  if (rx_tick && rx_bit == 3'd7) rx_nx = RX_STOP;
                RX_STOP:  if (rx_tick) rx_nx = RX_CLEAN;
                RX_CLEAN: rx_nx = RX_IDLE;
                default:  rx_nx = RX_IDLE;
            endcase
        end
    end

    always_comb begin
        rx_wr = (rx_st == RX_CLEAN) && En;
    end

    // ---------------- sequencer ----------------
    typedef enum logic [2:0] {
        SQ_FILL, SQ_RD_REQ, SQ_RD_WAIT, SQ_TX_LOAD, SQ_TX_BUSY
    } sq_st_t;

    sq_st_t          sq_st, sq_nx;
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [NW-1:0]   count;
    logic [7:0]      rd_data;
    logic            mem_we, mem_re, tx_start, rd_last;
    logic            drain_end, rd_adv;
    logic [7:0]      mem [DEPTH];

    assign rd_last = (rd_ptr == AW'(DEPTH - 1));

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            sq_st  <= SQ_FILL;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            LEDOut <= '0;
        end else begin
            sq_st <= sq_nx;
            if (mem_we) begin
                wr_ptr <= wr_ptr + 1'b1;
                count  <= count + 1'b1;
            end
            if (drain_end) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else if (rd_adv) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (rx_wr)
                LEDOut <= rx_byte;
        end
    end

    always_comb begin
        sq_nx = sq_st;
        unique case (sq_st)
            SQ_FILL:    if (En && count == NW'(DEPTH)) sq_nx = SQ_RD_REQ;
            SQ_RD_REQ:  if (En) sq_nx = SQ_RD_WAIT;
            SQ_RD_WAIT: if (En) sq_nx = SQ_TX_LOAD;
            SQ_TX_LOAD: if (En) sq_nx = SQ_TX_BUSY;
            SQ_TX_BUSY: begin
                // an aborted byte is restarted from the loaded read data
                if (!En)
                    sq_nx = SQ_TX_LOAD;
                else if (TxDone)
                    sq_nx = rd_last ? SQ_FILL : SQ_RD_REQ;
            end
            default:    sq_nx = SQ_FILL;
        endcase
    end

    always_comb begin
        mem_we    = rx_wr && (sq_st == SQ_FILL);
        mem_re    = (sq_st == SQ_RD_REQ);
        tx_start  = (sq_st == SQ_TX_LOAD) && En;
        drain_end = (sq_st == SQ_TX_BUSY) && TxDone && rd_last;
        rd_adv    = (sq_st == SQ_TX_BUSY) && TxDone && !rd_last;
    end

    // single-port RAM, registered read; contents survive reset
    always_ff @(posedge Clk) begin
        if (mem_we)
            mem[wr_ptr] <= rx_byte;
        else if (mem_re)
            rd_data <= mem[rd_ptr];
    end

    // ---------------- TX FSM ----------------
    typedef enum logic [2:0] {
        TX_IDLE, TX_START, TX_DATA, TX_STOP, TX_DONE
    } tx_st_t;

    tx_st_t          tx_st, tx_nx;
    logic [CW-1:0]   tx_cnt;
    logic [2:0]      tx_bit;
    logic [7:0]      tx_shift;
    logic            tx_tick;

    assign tx_tick = (tx_cnt == BIT_LAST);

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            tx_st    <= TX_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
        end else begin
            tx_st <= tx_nx;
            if (tx_st == TX_IDLE || tx_nx != tx_st || tx_tick)
                tx_cnt <= '0;
            else
                tx_cnt <= tx_cnt + 1'b1;
            if (tx_st != TX_DATA)
                tx_bit <= '0;
            else if (tx_tick)
                tx_bit <= tx_bit + 1'b1;
            if (tx_st == TX_IDLE && tx_start)
                tx_shift <= rd_data;
        end
    end

    always_comb begin
        tx_nx = tx_st;
        if (!En) begin
            tx_nx = TX_IDLE;
        end else begin
            unique case (tx_st)
                TX_IDLE:  if (tx_start) tx_nx = TX_START;
                TX_START: if (tx_tick) tx_nx = TX_DATA;
                TX_DATA:  if (tx_tick && tx_bit == 3'd7) tx_nx = TX_STOP;
                TX_STOP:  if (tx_tick) tx_nx = TX_DONE;
                TX_DONE:  tx_nx = TX_IDLE;
                default:  tx_nx = TX_IDLE;
            endcase
        end
    end

    always_comb begin
        Tx     = 1'b1;
        TxDone = 1'b0;
        unique case (tx_st)
            TX_START: Tx = 1'b0;
            TX_DATA:  Tx = tx_shift[tx_bit];
            TX_DONE:  TxDone = 1'b1;
            default:  Tx = 1'b1;
        endcase
        // disable forces the line idle without waiting for the state update
        if (!En) begin
            Tx     = 1'b1;
            TxDone = 1'b0;
        end
    end

    // ---------------- seven-segment display ----------------
`ifdef UART_BRAM_LOOPBACK_SSD_EN
    function automatic logic [6:0] seg7(input logic [3:0] h);
        case (h)
            4'h0:    seg7 = 7'b1000000;
            4'h1:    seg7 = 7'b1111001;
            4'h2:    seg7 = 7'b0100100;
            4'h3:    seg7 = 7'b0110000;
            4'h4:    seg7 = 7'b0011001;
            4'h5:    seg7 = 7'b0010010;
            4'h6:    seg7 = 7'b0000010;
            4'h7:    seg7 = 7'b1111000;
            4'h8:    seg7 = 7'b0000000;
            4'h9:    seg7 = 7'b0010000;
            4'hA:    seg7 = 7'b0001000;
            4'hB:    seg7 = 7'b0000011;
            4'hC:    seg7 = 7'b1000110;
            4'hD:    seg7 = 7'b0100001;
            4'hE:    seg7 = 7'b0000110;
            default: seg7 = 7'b0001110;
        endcase
    endfunction

    logic [REFRESH_BITS-1:0] refresh;
    logic [1:0]              digit;
    logic [3:0]              nib, sel;
    logic                    blank;

    assign digit = refresh[REFRESH_BITS-1 -: 2];

    always_comb begin
        nib   = LEDOut[3:0];
        sel   = 4'b1110;
        blank = 1'b0;
        unique case (digit)
            2'd0: begin nib = LEDOut[3:0]; sel = 4'b1110; end
            2'd1: begin nib = LEDOut[7:4]; sel = 4'b1101; end
            2'd2: begin nib = 4'(count);   sel = 4'b1011; end
            default: begin blank = 1'b1;   sel = 4'b0111; end
        endcase
    end

    // registered so the display reads blank while in reset
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            refresh    <= '0;
            SSD_Out    <= 8'hFF;
            SSD_Select <= 4'b1111;
        end else begin
            refresh    <= refresh + 1'b1;
            SSD_Select <= sel;
            SSD_Out    <= blank ? 8'hFF : {1'b1, seg7(nib)};
        end
    end
`else
    assign SSD_Out    = 8'hFF;
    assign SSD_Select = 4'b1111;
`endif

endmodule

// File: tb/tb_uart_bram_loopback.sv
// Bench for uart_bram_loopback: directed RX frames, scoreboard of expected
// TX bytes checked by a frame monitor, plus glitch, En and reset cases.
module tb_uart_bram_loopback;

    localparam int CPB   = 16;
    localparam int LIMIT = 4000;

    logic       Clk = 1'b0;
    logic       Rst_n = 1'b0;
    logic       En = 1'b0;
    logic       Rx = 1'b1;
    logic       Tx, TxDone;
    logic [7:0] LEDOut, SSD_Out;
    logic [3:0] SSD_Select;

    int n_cmp = 0;
    int n_err = 0;
    int mon_frames = 0;
    int done_pulses = 0;
    logic [7:0] exp_q[$];
    logic [7:0] mon_b;
    bit         mon_ab;

    always #5 Clk = ~Clk;

    uart_bram_loopback #(.CLKS_PER_BIT(CPB), .DEPTH(8)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .En(En), .Rx(Rx),
        .Tx(Tx), .TxDone(TxDone), .LEDOut(LEDOut),
        .SSD_Out(SSD_Out), .SSD_Select(SSD_Select)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        Rx = 1'b0;
        tick(CPB);
        for (int j = 0; j < 8; j++) begin
            Rx = b[j];
            tick(CPB);
        end
        Rx = 1'b1;
        tick(CPB);
    endtask

    task automatic wait_frames(input int n, input string tag);
        for (int k = 0; k < LIMIT && mon_frames < n; k++) tick(1);
        check(tag, mon_frames, n);
    endtask

    task automatic wait_tx_low(input string tag);
        for (int k = 0; k < LIMIT && Tx !== 1'b0; k++) tick(1);
        check(tag, Tx, 0);
    endtask

    always @(negedge Clk) if (TxDone === 1'b1) done_pulses++;

    // frame monitor: cycle-exact decode of each Tx frame
    initial begin
        forever begin
            @(negedge Clk);
            if (Rst_n && En && Tx === 1'b0) begin
                mon_ab = 1'b0;
                mon_b  = '0;
                for (int i = 1; i <= 10 * CPB; i++) begin
                    @(negedge Clk);
                    if (!En || !Rst_n) begin
                        mon_ab = 1'b1;
                        break;
                    end
                    if (i == CPB / 2) check("tx_start_bit", Tx, 0);
                    if (i > CPB / 2 && i < CPB / 2 + 9 * CPB &&
                        (i - CPB / 2) % CPB == 0)
                        mon_b[(i - CPB / 2) / CPB - 1] = Tx;
                    if (i == CPB / 2 + 9 * CPB) check("tx_stop_bit", Tx, 1);
                end
                if (!mon_ab) begin
                    check("tx_done_at_frame_end", TxDone, 1);
                    check("tx_byte_expected", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0)
                        check("tx_byte", mon_b, exp_q.pop_front());
                    mon_frames++;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tick(3);
        check("rst_tx", Tx, 1);
        check("rst_txdone", TxDone, 0);
        check("rst_led", LEDOut, 8'h00);
        check("rst_ssd_out", SSD_Out, 8'hFF);
        check("rst_ssd_sel", SSD_Select, 4'hF);
        Rst_n = 1'b1;
        En = 1'b1;
        tick(5);

        // first byte: shown on LEDs, nothing transmitted
        exp_q.push_back(8'h61);
        send_byte(8'h61);
        tick(4);
        check("first_led", LEDOut, 8'h61);
        check("first_tx_idle", Tx, 1);
        check("first_no_done", done_pulses, 0);

        // short low pulse must not be taken as a start bit
        Rx = 1'b0;
        tick(CPB / 2 - 3);
        Rx = 1'b1;
        tick(3 * CPB);
        check("glitch_led", LEDOut, 8'h61);

        for (int b = 8'h62; b <= 8'h68; b++) begin
            exp_q.push_back(8'(b));
            send_byte(8'(b));
            if (b == 8'h67) check("no_early_drain", done_pulses, 0);
        end
        wait_tx_low("drain_start");

        // byte during drain: LEDs only, not buffered
        send_byte(8'h55);
        tick(4);
        check("drain_rx_led", LEDOut, 8'h55);
        wait_frames(8, "drain1_frames");
        check("drain1_done_pulses", done_pulses, 8);
        check("drain1_queue_empty", exp_q.size(), 0);
        tick(10);
        check("post_drain_tx_idle", Tx, 1);

        // second fill: must again need a full 8 bytes
        for (int b = 8'h61; b <= 8'h68; b++) begin
            exp_q.push_back(8'(b));
            send_byte(8'(b));
            if (b == 8'h67) check("fill_after_drain", mon_frames, 8);
        end

        // abort the 4th transmitted byte with En low
        wait_frames(11, "drain2_three_frames");
        wait_tx_low("fourth_byte_start");
        tick(3 * CPB);
        En = 1'b0;
        #1;
        check("en_off_tx", Tx, 1);
        tick(1);
        check("en_off_tx_cycle", Tx, 1);
        check("en_off_txdone", TxDone, 0);
        tick(20);
        check("en_off_hold_tx", Tx, 1);
        En = 1'b1;
        wait_frames(16, "drain2_frames");
        check("drain2_done_pulses", done_pulses, 16);
        check("drain2_queue_empty", exp_q.size(), 0);

        // reset in the middle of a received frame
        Rx = 1'b0;
        tick(CPB);
        Rx = 1'b1;
        tick(2 * CPB);
        #2;
        Rst_n = 1'b0;
        #1;
        check("midrst_tx", Tx, 1);
        check("midrst_txdone", TxDone, 0);
        check("midrst_led", LEDOut, 8'h00);
        check("midrst_ssd_out", SSD_Out, 8'hFF);
        check("midrst_ssd_sel", SSD_Select, 4'hF);
        tick(2);
        Rst_n = 1'b1;
        Rx = 1'b1;
        tick(2 * CPB);
        send_byte(8'h41);
        tick(4);
        check("post_rst_led", LEDOut, 8'h41);
        check("post_rst_tx_idle", Tx, 1);
        check("post_rst_no_done", done_pulses, 16);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
